// File: rtl/cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// cache_refill_ctrl
//
// Miss-handling sequencer for the L1 cache. A miss accepted in IDLE can first
// write the dirty victim line back (AW, four W beats, B). It then refills the
// missing line (AR, four R beats). Each returned word goes straight into the
// data array through the fill port in the same cycle. A one-cycle refill_done
// pulse releases the cache pipeline, and err is valid alongside it.
//
// Build option:
//   CRITICAL_WORD_FIRST_EN - when defined, the refill is a WRAP burst that
//   starts at the missing word. When undefined (the default), it is an INCR
//   burst from word 0. The write-back is always INCR from word 0.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   miss_req/miss_addr miss request and byte address (sampled in IDLE only)
//   victim_dirty/addr/line  victim line to write back (word0 in low bits)
//   busy               controller not IDLE
//   refill_done, err   one-cycle completion pulse and its error flag
//   fill_we/idx/data   data-array word write port
//   ar_*, r_*          read burst channel (address / data)
//   aw_*, w_*, b_*     write burst channel (address / data / response)
// ---------------------------------------------------------------------------
module cache_refill_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  miss_req,
   input  logic [ADDR_W-1:0]     miss_addr,
   input  logic                  victim_dirty,
   input  logic [ADDR_W-1:0]     victim_addr,
   input  logic [4*DATA_W-1:0]   victim_line,
   output logic                  busy,
   output logic                  refill_done,
   output logic                  err,
   output logic                  fill_we,
   output logic [1:0]            fill_idx,
   output logic [DATA_W-1:0]     fill_data,
   output logic                  ar_valid,
   input  logic                  ar_ready,
   output logic [ADDR_W-1:0]     ar_addr,
   output logic [1:0]            ar_burst,
   input  logic                  r_valid,
   output logic                  r_ready,
   input  logic [DATA_W-1:0]     r_data,
   input  logic [1:0]            r_resp,
   input  logic                  r_last,
   output logic                  aw_valid,
   input  logic                  aw_ready,
   output logic [ADDR_W-1:0]     aw_addr,
   output logic                  w_valid,
   input  logic                  w_ready,
   output logic [DATA_W-1:0]     w_data,
   output logic                  w_last,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [1:0]            b_resp
);

   typedef enum logic [2:0] {
      IDLE, WB_ADDR, WB_DATA, WB_RESP, RF_ADDR, RF_DATA, DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-4){1'b1}}, 4'h0};
`ifdef CRITICAL_WORD_FIRST_EN
   localparam logic [ADDR_W-1:0] RD_MASK  = {{(ADDR_W-2){1'b1}}, 2'b00};
   localparam logic [1:0]        RD_BURST = 2'b10;  // WRAP
`else
   localparam logic [ADDR_W-1:0] RD_MASK  = LINE_MASK;
   localparam logic [1:0]        RD_BURST = 2'b01;  // INCR
`endif

   state_t              state;
   logic [1:0]          count;       // beat counter; count==3 marks the last beat
   logic [1:0]          start_idx;   // first word of the refill burst
   logic [4*DATA_W-1:0] line_q;      // latched victim line
   logic [ADDR_W-1:0]   rd_addr_q;   // latched refill burst address

   // The fill port follows the R channel combinationally so that each word is
   // written in the cycle it is accepted. r_ready is only high in RF_DATA,
   // so the port is quiet (all zeros) in every other state and during reset.
   assign fill_we   = r_ready & r_valid;
   assign fill_idx  = fill_we ? 2'(start_idx + count) : 2'b00;
   assign fill_data = fill_we ? r_data : '0;

   // NOTE: every register here, the latched line included, is a plain flop
   // with an async reset, so a mid-burst reset leaves no stale state behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         count       <= 2'b00;
         start_idx   <= 2'b00;
         line_q      <= '0;
         rd_addr_q   <= '0;
         busy        <= 1'b0;
         refill_done <= 1'b0;
         err         <= 1'b0;
         ar_valid    <= 1'b0;
         ar_addr     <= '0;
         ar_burst    <= 2'b00;
         r_ready     <= 1'b0;
         aw_valid    <= 1'b0;
         aw_addr     <= '0;
         w_valid     <= 1'b0;
         w_data      <= '0;
         w_last      <= 1'b0;
         b_ready     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout; every branch below reads
         // the pre-edge value of count/state, never a value updated this cycle.
         refill_done <= 1'b0;
         case (state)
            IDLE: begin
               if (miss_req) begin
                  busy      <= 1'b1;
                  err       <= 1'b0;
                  count     <= 2'b00;
                  line_q    <= victim_line;
                  rd_addr_q <= miss_addr & RD_MASK;
`ifdef CRITICAL_WORD_FIRST_EN
                  start_idx <= miss_addr[3:2];
`else
                  start_idx <= 2'b00;
`endif
                  if (victim_dirty) begin
                     state    <= WB_ADDR;
                     aw_valid <= 1'b1;
                     aw_addr  <= victim_addr & LINE_MASK;
                  end else begin
                     state    <= RF_ADDR;
                     ar_valid <= 1'b1;
                     ar_addr  <= miss_addr & RD_MASK;
                     ar_burst <= RD_BURST;
                  end
               end
            end

            WB_ADDR: begin
               if (aw_ready) begin
                  state    <= WB_DATA;
                  aw_valid <= 1'b0;
                  aw_addr  <= '0;
                  w_valid  <= 1'b1;
                  w_data   <= line_q[0 +: DATA_W];
                  w_last   <= 1'b0;
               end
            end

            WB_DATA: begin
               // w_data/w_last are registered one beat ahead: on each accepted
               // beat they are reloaded with the next word of the line.
               if (w_ready) begin
                  if (count == 2'd3) begin
                     state   <= WB_RESP;
                     count   <= 2'b00;
                     w_valid <= 1'b0;
                     w_data  <= '0;
                     w_last  <= 1'b0;
                     b_ready <= 1'b1;
                  end else begin
                     count  <= count + 2'd1;
                     w_data <= line_q[int'(count + 2'd1) * DATA_W +: DATA_W];
                     w_last <= (count == 2'd2);
                  end
               end
            end

            WB_RESP: begin
               if (b_valid) begin
                  if (b_resp != 2'b00) err <= 1'b1;
                  state    <= RF_ADDR;
                  b_ready  <= 1'b0;
                  ar_valid <= 1'b1;
                  ar_addr  <= rd_addr_q;
                  ar_burst <= RD_BURST;
               end
            end

            RF_ADDR: begin
               if (ar_ready) begin
                  state    <= RF_DATA;
                  ar_valid <= 1'b0;
                  ar_addr  <= '0;
                  ar_burst <= 2'b00;
                  r_ready  <= 1'b1;
               end
            end

            RF_DATA: begin
               if (r_valid) begin
                  // Bad response or r_last out of step with the beat count.
                  if (r_resp != 2'b00 || r_last != (count == 2'd3)) err <= 1'b1;
                  count <= count + 2'd1;  // wraps 3->0 exactly at burst end
                  if (count == 2'd3) begin
                     state       <= DONE;
                     r_ready     <= 1'b0;
                     refill_done <= 1'b1;
                  end
               end
            end

            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_refill_ctrl
//
// Scoreboard bench for cache_refill_ctrl. The driver issues misses and pushes
// the expected bus traffic (AW address, W beats, AR address/burst, fill
// writes, final err) into queues. A monitor process plays the memory slave
// with random or forced-high handshakes. It pops and compares each expected
// item whenever the DUT presents the matching transfer. Memory contents are
// a fixed hash of the word address.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cache_refill_ctrl;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                miss_req = 1'b0;
   logic [ADDR_W-1:0]   miss_addr = '0;
   logic                victim_dirty = 1'b0;
   logic [ADDR_W-1:0]   victim_addr = '0;
   logic [4*DATA_W-1:0] victim_line = '0;
   logic                busy, refill_done, err, fill_we;
   logic [1:0]          fill_idx;
   logic [DATA_W-1:0]   fill_data;
   logic                ar_valid, ar_ready = 1'b0;
   logic [ADDR_W-1:0]   ar_addr;
   logic [1:0]          ar_burst;
   logic                r_valid = 1'b0, r_ready;
   logic [DATA_W-1:0]   r_data = '0;
   logic [1:0]          r_resp = 2'b00;
   logic                r_last = 1'b0;
   logic                aw_valid, aw_ready = 1'b0;
   logic [ADDR_W-1:0]   aw_addr;
   logic                w_valid, w_ready = 1'b0;
   logic [DATA_W-1:0]   w_data;
   logic                w_last;
   logic                b_valid = 1'b0, b_ready;
   logic [1:0]          b_resp = 2'b00;

   cache_refill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .miss_req(miss_req), .miss_addr(miss_addr),
      .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_line(victim_line),
      .busy(busy), .refill_done(refill_done), .err(err),
      .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_burst(ar_burst),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
      .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0]  miss_addr;
      logic         dirty;
      logic [31:0]  victim_addr;
      logic [127:0] line;
      logic         b_err;
      int           r_err_beat;  // -1: none
      int           last_bad;    // -1: none, else beat whose r_last is wrong
   } txn_t;
   typedef struct { logic [31:0] data; logic last; } w_exp_t;
   typedef struct { logic [31:0] addr; logic [1:0] burst; } ar_exp_t;
   typedef struct { logic [1:0] idx; logic [31:0] data; } fill_exp_t;

   logic [31:0] exp_aw[$];
   w_exp_t      exp_w[$];
   ar_exp_t     exp_ar[$];
   fill_exp_t   exp_fill[$];
   logic        exp_err[$];
   txn_t        plan_q[$];
   bit          rpat[$];

   int  n_checks = 0;
   int  n_pass   = 0;
   bit  all_high = 1'b1;
   int  fill_count = 0;
   int  done_count = 0;
   int  last_done_cyc = 0;
   int  last_beat_cyc = 0;
   int  accept_cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Reference model: what the bus and the data array must see for one miss.
   task automatic push_expect(input txn_t t);
      logic [31:0] base;
      logic [1:0]  first;
      w_exp_t      we;
      ar_exp_t     ae;
      fill_exp_t   fe;
      if (t.dirty) begin
         exp_aw.push_back(t.victim_addr & 32'hFFFF_FFF0);
         for (int k = 0; k < 4; k++) begin
            we.data = t.line[k*32 +: 32];
            we.last = (k == 3);
            exp_w.push_back(we);
         end
      end
      base = t.miss_addr & 32'hFFFF_FFF0;
`ifdef CRITICAL_WORD_FIRST_EN
      ae.addr  = t.miss_addr & 32'hFFFF_FFFC;
      ae.burst = 2'b10;
      first    = t.miss_addr[3:2];
`else
      ae.addr  = base;
      ae.burst = 2'b01;
      first    = 2'd0;
`endif
      exp_ar.push_back(ae);
      for (int k = 0; k < 4; k++) begin
         fe.idx  = 2'((int'(first) + k) % 4);
         fe.data = mem_word(base + 32'(int'(fe.idx) * 4));
         exp_fill.push_back(fe);
      end
      exp_err.push_back((t.dirty && t.b_err) || t.r_err_beat >= 0 || t.last_bad >= 0);
      plan_q.push_back(t);
   endtask

   function automatic txn_t mk_txn(input logic [31:0] ma, input logic d, input logic [31:0] va,
                                   input logic [127:0] ln);
      txn_t t;
      t.miss_addr = ma; t.dirty = d; t.victim_addr = va; t.line = ln;
      t.b_err = 1'b0; t.r_err_beat = -1; t.last_bad = -1;
      return t;
   endfunction

   // ---------------- monitor / memory slave ----------------
   initial begin : monitor
      int          wb_beat;
      int          r_beat;
      bit          b_pending;
      bit          r_active;
      bit          prev_done;
      logic [31:0] r_base;
      logic [1:0]  r_start;
      logic [1:0]  widx;
      w_exp_t      we;
      ar_exp_t     ae;
      fill_exp_t   fe;
      logic        ee;
      wb_beat = 0; r_beat = 0; b_pending = 0; r_active = 0; prev_done = 0;
      r_base = '0; r_start = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            wb_beat = 0; r_beat = 0; b_pending = 0; r_active = 0; prev_done = 0;
            exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_fill.delete();
            exp_err.delete(); plan_q.delete(); rpat.delete();
            aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
            r_last = 0; r_resp = 0; b_resp = 0;
            continue;
         end
         aw_ready = all_high || ($urandom_range(0, 1) == 1);
         w_ready  = all_high || ($urandom_range(0, 1) == 1);
         ar_ready = all_high || ($urandom_range(0, 1) == 1);
         b_valid  = b_pending && (all_high || ($urandom_range(0, 1) == 1));
         b_resp   = (b_valid && plan_q.size() != 0 && plan_q[0].b_err) ? 2'b10 : 2'b00;
         if (r_active) begin
            if (rpat.size() != 0) r_valid = rpat.pop_front();
            else r_valid = all_high || ($urandom_range(0, 2) != 0);
         end else r_valid = 1'b0;
         if (r_valid) begin
            widx   = 2'((int'(r_start) + r_beat) % 4);
            r_data = mem_word(r_base + 32'(int'(widx) * 4));
            r_resp = (plan_q.size() != 0 && plan_q[0].r_err_beat == r_beat) ? 2'b10 : 2'b00;
            r_last = (r_beat == 3) != (plan_q.size() != 0 && plan_q[0].last_bad == r_beat);
         end else begin
            r_data = $urandom; r_resp = 2'b00; r_last = 1'b0;
         end
         #1;
         if (aw_valid && aw_ready) begin
            check("aw_expected", 64'(exp_aw.size() != 0), 64'd1);
            if (exp_aw.size() != 0) check("aw_addr", 64'(aw_addr), 64'(exp_aw.pop_front()));
         end
         if (w_valid && w_ready) begin
            check("w_expected", 64'(exp_w.size() != 0), 64'd1);
            if (exp_w.size() != 0) begin
               we = exp_w.pop_front();
               check("w_data", 64'(w_data), 64'(we.data));
               check("w_last", 64'(w_last), 64'(we.last));
            end
            wb_beat++;
            if (wb_beat == 4) begin wb_beat = 0; b_pending = 1; end
         end
         if (b_valid && b_ready) b_pending = 0;
         if (ar_valid && ar_ready) begin
            check("ar_expected", 64'(exp_ar.size() != 0), 64'd1);
            if (exp_ar.size() != 0) begin
               ae = exp_ar.pop_front();
               check("ar_addr", 64'(ar_addr), 64'(ae.addr));
               check("ar_burst", 64'(ar_burst), 64'(ae.burst));
            end
            r_active = 1; r_beat = 0;
            r_base  = ar_addr & 32'hFFFF_FFF0;
            r_start = ar_addr[3:2];
         end
         if (r_valid && r_ready) begin
            check("fill_we_on_beat", 64'(fill_we), 64'd1);
            check("fill_expected", 64'(exp_fill.size() != 0), 64'd1);
            if (exp_fill.size() != 0) begin
               fe = exp_fill.pop_front();
               check("fill_idx", 64'(fill_idx), 64'(fe.idx));
               check("fill_data", 64'(fill_data), 64'(fe.data));
            end
            fill_count++;
            last_beat_cyc = cyc;
            r_beat++;
            if (r_beat == 4) r_active = 0;
         end else if (fill_we) begin
            check("fill_we_without_beat", 64'(fill_we), 64'd0);
         end
         if (refill_done) begin
            check("done_single_pulse", 64'(prev_done), 64'd0);
            check("busy_at_done", 64'(busy), 64'd1);
            check("done_expected", 64'(exp_err.size() != 0), 64'd1);
            if (exp_err.size() != 0) begin
               ee = exp_err.pop_front();
               check("err_at_done", 64'(err), 64'(ee));
            end
            check("done_after_last_beat", 64'(cyc), 64'(last_beat_cyc + 1));
            if (plan_q.size() != 0) void'(plan_q.pop_front());
            done_count++;
            last_done_cyc = cyc;
         end
         prev_done = refill_done;
      end
   end

   // ---------------- driver ----------------
   task automatic wait_idle();
      int n = 0;
      do begin @(negedge clk); #2; n++; end while (busy && n < 1000);
      check("idle_within_bound", 64'(n < 1000), 64'd1);
   endtask

   task automatic wait_done(input int prev);
      int n = 0;
      while (done_count <= prev && n < 1000) begin @(negedge clk); #2; n++; end
      check("done_within_bound", 64'(done_count > prev), 64'd1);
   endtask

   task automatic issue(input txn_t t, input bit hold);
      wait_idle();
      miss_req     = 1'b1;
      miss_addr    = t.miss_addr;
      victim_dirty = t.dirty;
      victim_addr  = t.victim_addr;
      victim_line  = t.line;
      push_expect(t);
      accept_cyc   = cyc;
      @(negedge clk); #2;
      if (!hold) begin
         // Scramble the miss inputs so a controller that fails to latch them
         // shows up as wrong addresses or data.
         miss_req     = 1'b0;
         miss_addr    = $urandom;
         victim_dirty = 1'($urandom);
         victim_addr  = $urandom;
         victim_line  = {$urandom, $urandom, $urandom, $urandom};
      end
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : driver
      txn_t t;
      int   d;
      int   f0;
      int   n;
      repeat (3) @(negedge clk);
      #2;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_refill_done", 64'(refill_done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_fill", 64'({fill_we, fill_idx, fill_data}), 64'd0);
      check("rst_valids", 64'({ar_valid, aw_valid, w_valid, w_last, r_ready, b_ready}), 64'd0);
      check("rst_addrs", 64'({ar_addr, aw_addr}), 64'd0);
      check("rst_wdata_burst", 64'({w_data, ar_burst}), 64'd0);
      rst = 1'b0;

      // Clean miss, everything ready: done 6 cycles after acceptance.
      all_high = 1;
      d = done_count;
      issue(mk_txn(32'h0000_1234, 1'b0, 32'h0, 128'h0), 1'b0);
      wait_done(d);
      check("clean_latency", 64'(last_done_cyc - accept_cyc), 64'd6);

      // Dirty miss: write-back adds 6 cycles.
      d = done_count;
      issue(mk_txn(32'h0000_4568, 1'b1, 32'h0000_8000,
                   {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0}), 1'b0);
      wait_done(d);
      check("dirty_latency", 64'(last_done_cyc - accept_cyc), 64'd12);

      // R backpressure pattern 1,0,0,1,0,1,1: beats land in cycles 2,5,7,8.
      rpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      d = done_count; f0 = fill_count;
      issue(mk_txn(32'h0000_ABCC, 1'b0, 32'h0, 128'h0), 1'b0);
      wait_done(d);
      check("gap_fill_count", 64'(fill_count - f0), 64'd4);
      check("gap_latency", 64'(last_done_cyc - accept_cyc), 64'd9);

      // Write-back error: refill still completes, err reported.
      t = mk_txn(32'h0001_0008, 1'b1, 32'h0002_0000, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      t.b_err = 1'b1;
      d = done_count;
      issue(t, 1'b0);
      wait_done(d);

      // r_last early on the second beat: four fills, err reported.
      t = mk_txn(32'h0003_0014, 1'b0, 32'h0, 128'h0);
      t.last_bad = 1;
      d = done_count; f0 = fill_count;
      issue(t, 1'b0);
      wait_done(d);
      check("early_last_fill_count", 64'(fill_count - f0), 64'd4);

      // Reset after two refill beats: immediate abort, then a clean retry.
      f0 = fill_count;
      issue(mk_txn(32'h0004_0000, 1'b0, 32'h0, 128'h0), 1'b0);
      n = 0;
      while (fill_count < f0 + 2 && n < 100) begin @(negedge clk); #2; n++; end
      check("two_beats_seen", 64'(fill_count - f0), 64'd2);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_fill_we", 64'(fill_we), 64'd0);
      check("abort_r_ready", 64'(r_ready), 64'd0);
      check("abort_done", 64'(refill_done), 64'd0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      d = done_count;
      issue(mk_txn(32'h0004_0000, 1'b0, 32'h0, 128'h0), 1'b0);
      wait_done(d);
      check("retry_latency", 64'(last_done_cyc - accept_cyc), 64'd6);

      // miss_req held through DONE: one more acceptance, in the cycle after done.
      t = mk_txn(32'h0005_0030, 1'b0, 32'h0, 128'h0);
      push_expect(t);  // the second acceptance of the same held request
      d = done_count;
      issue(t, 1'b1);
      wait_done(d);
      f0 = last_done_cyc;
      @(negedge clk); #2;
      check("held_idle_after_done", 64'(busy), 64'd0);
      @(negedge clk); #2;
      check("held_reaccepted", 64'(busy), 64'd1);
      miss_req = 1'b0;
      wait_done(d + 1);
      check("held_second_done", 64'(last_done_cyc - f0), 64'd7);
      repeat (4) @(negedge clk);
      #2;
      check("held_no_third", 64'(busy), 64'd0);

      // Randomized misses with random handshakes and occasional errors.
      all_high = 0;
      for (int i = 0; i < 40; i++) begin
         t = mk_txn($urandom, 1'($urandom), $urandom & 32'hFFFF_FFF0,
                    {$urandom, $urandom, $urandom, $urandom});
         if ($urandom_range(0, 5) == 0) t.b_err = 1'b1;
         if ($urandom_range(0, 7) == 0) t.r_err_beat = $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0) t.last_bad = $urandom_range(0, 3);
         d = done_count;
         issue(t, 1'b0);
         wait_done(d);
      end

      wait_idle();
      repeat (3) @(negedge clk);
      #2;
      check("queues_drained",
            64'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_fill.size() + exp_err.size()),
            64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
